// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants, capture FSM states and decode function
package seg7_pkg;

  localparam int SEG7_DP_BIT = 7;

  localparam logic [6:0] SEG7_0 = 7'h3f;
  localparam logic [6:0] SEG7_1 = 7'h06;
  localparam logic [6:0] SEG7_2 = 7'h5b;
  localparam logic [6:0] SEG7_3 = 7'h4f;
  localparam logic [6:0] SEG7_4 = 7'h66;
  localparam logic [6:0] SEG7_5 = 7'h6d;
  localparam logic [6:0] SEG7_6 = 7'h7d;
  localparam logic [6:0] SEG7_7 = 7'h27;
  localparam logic [6:0] SEG7_8 = 7'h7f;
  localparam logic [6:0] SEG7_9 = 7'h6f;
  localparam logic [6:0] SEG7_A = 7'h5f;
  localparam logic [6:0] SEG7_B = 7'h7c;
  localparam logic [6:0] SEG7_C = 7'h58;
  localparam logic [6:0] SEG7_D = 7'h5e;
  localparam logic [6:0] SEG7_E = 7'h7b;
  localparam logic [6:0] SEG7_F = 7'h71;

  typedef enum logic {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] pat);
    seg7_dec_t r;
    r.valid  = 1'b1;
    r.nibble = 4'h0;
    case (pat)
      SEG7_0:  r.nibble = 4'h0;
      SEG7_1:  r.nibble = 4'h1;
      SEG7_2:  r.nibble = 4'h2;
      SEG7_3:  r.nibble = 4'h3;
      SEG7_4:  r.nibble = 4'h4;
      SEG7_5:  r.nibble = 4'h5;
      SEG7_6:  r.nibble = 4'h6;
      SEG7_7:  r.nibble = 4'h7;
      SEG7_8:  r.nibble = 4'h8;
      SEG7_9:  r.nibble = 4'h9;
      SEG7_A:  r.nibble = 4'hA;
      SEG7_B:  r.nibble = 4'hB;
      SEG7_C:  r.nibble = 4'hC;
      SEG7_D:  r.nibble = 4'hD;
      SEG7_E:  r.nibble = 4'hE;
      SEG7_F:  r.nibble = 4'hF;
      default: r.valid  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to hex nibble decoder
import seg7_pkg::*;

module seg7_pattern_decode (
  input  logic [6:0] pat,
  output logic       valid,
  output logic [3:0] nibble
);

  seg7_dec_t dec;

  always_comb begin
    dec    = seg7_decode(pat);
    valid  = dec.valid;
    nibble = dec.nibble;
  end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - samples a multiplexed 7-segment bus and publishes stable decoded frames
import seg7_pkg::*;

module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_seg_d,
  input  logic [7:0]            i_seg_com,
  output logic [4*DIGITS-1:0]   o_digits,
  output logic                  o_valid,
  output logic                  o_locked,
  output logic                  o_frame_err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam logic [7:0]    COM_MASK = 8'((1 << DIGITS) - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [SW-1:0] SF_MAX   = SW'(STABLE_FRAMES);

  logic [7:0]          s_d;
  logic [7:0]          s_com;
  logic [7:0]          s_com_prev;
  cap_state_e          state, state_n;
  logic [IW-1:0]       exp_idx, exp_n;
  logic [4*DIGITS-1:0] frame, frame_n, frame_ins;
  logic [4*DIGITS-1:0] last_frame, last_n;
  logic [SW-1:0]       stab_cnt, stab_n;

  logic          new_strobe;
  logic          com_legal;
  logic [IW-1:0] com_idx;
  logic          pat_valid;
  logic [3:0]    pat_nib;
  logic          good_pat;
  logic          complete;
  logic          abort;
  logic          publish;
  logic          dp_unused;

  // Decimal point carries no digit information.
  assign dp_unused  = s_d[SEG7_DP_BIT];
  assign new_strobe = (s_com != s_com_prev);
  assign com_legal  = $onehot(s_com) && ((s_com & ~COM_MASK) == 8'd0);
  assign good_pat   = com_legal && pat_valid;

  seg7_pattern_decode u_dec (
    .pat    (s_d[6:0]),
    .valid  (pat_valid),
    .nibble (pat_nib)
  );

  always_comb begin
    com_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (s_com[i]) com_idx = IW'(i);
    end
  end

  always_comb begin
    frame_ins = frame;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == com_idx) frame_ins[4*i +: 4] = pat_nib;
    end
  end

  always_comb begin
    state_n  = state;
    exp_n    = exp_idx;
    frame_n  = frame;
    complete = 1'b0;
    abort    = 1'b0;
    if (new_strobe) begin
      case (state)
        HUNT: begin
          if (good_pat && com_idx == '0) begin
            frame_n = frame_ins;
            exp_n   = IW'(1);
            if (DIGITS == 1) complete = 1'b1;
            else             state_n  = CAPTURE;
          end
        end
        CAPTURE: begin
          if (good_pat && com_idx == exp_idx) begin
            frame_n = frame_ins;
            exp_n   = exp_idx + IW'(1);
            if (com_idx == LAST_IDX) begin
              complete = 1'b1;
              state_n  = HUNT;
            end
          end else if (good_pat && com_idx == '0) begin
            abort   = 1'b1;
            frame_n = frame_ins;
            exp_n   = IW'(1);
          end else begin
            abort   = 1'b1;
            state_n = HUNT;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // Stability tracking: publish only on the transition into the saturated count.
  always_comb begin
    stab_n  = stab_cnt;
    last_n  = last_frame;
    publish = 1'b0;
    if (complete) begin
      if (frame_n == last_frame) begin
        if (stab_cnt < SF_MAX) begin
          stab_n  = stab_cnt + SW'(1);
          publish = (stab_cnt + SW'(1) == SF_MAX);
        end
      end else begin
        stab_n  = SW'(1);
        last_n  = frame_n;
        publish = (STABLE_FRAMES == 1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_d         <= '0;
      s_com       <= '0;
      s_com_prev  <= '0;
      state       <= HUNT;
      exp_idx     <= '0;
      frame       <= '0;
      last_frame  <= '0;
      stab_cnt    <= '0;
      o_digits    <= '0;
      o_valid     <= 1'b0;
      o_locked    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      s_d         <= i_seg_d;
      s_com       <= i_seg_com;
      s_com_prev  <= s_com;
      state       <= state_n;
      exp_idx     <= exp_n;
      frame       <= frame_n;
      last_frame  <= last_n;
      stab_cnt    <= stab_n;
      o_valid     <= publish;
      o_frame_err <= abort;
      if (publish) o_digits <= frame_n;
      if (complete) o_locked <= publish || (frame_n == o_digits);
    end
  end

endmodule
